// File: rtl/dual_cam_frame_arbiter_pkg.sv
// Shared types and defaults for the dual-camera frame arbiter.
// Arbiter states, virtual-channel width, default gap/timeout lengths and the per-camera beat struct.
package dual_cam_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } arb_state_e;

    localparam int VC_W       = 2;
    localparam int DATA_W     = 8;
    localparam int DROP_CNT_W = 16;

    localparam int unsigned DEFAULT_GAP_CYCLES     = 32'd64;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'h0100_0000;

    typedef struct packed {
        logic              fv;
        logic              lv;
        logic [DATA_W-1:0] data;
    } cam_beat_t;

endpackage

// File: rtl/dual_cam_frame_arbiter_if.sv
// Camera inputs, TX handshake and arbitrated output stream of the frame arbiter.
// slave = arbiter side, master = camera/TX side.
interface dual_cam_frame_arbiter_if;
    import dual_cam_frame_arbiter_pkg::*;

    logic              cam0_fv;
    logic              cam0_lv;
    logic [DATA_W-1:0] cam0_data;
    logic              cam1_fv;
    logic              cam1_lv;
    logic [DATA_W-1:0] cam1_data;
    logic [1:0]        cam_en;
    logic              tx_ready;

    logic              out_fv;
    logic              out_lv;
    logic [DATA_W-1:0] out_data;
    logic [VC_W-1:0]   out_vc;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  cam0_fv, cam0_lv, cam0_data,
        input  cam1_fv, cam1_lv, cam1_data,
        input  cam_en, tx_ready,
        output out_fv, out_lv, out_data, out_vc, busy, timeout_err
    );

    modport master (
        output cam0_fv, cam0_lv, cam0_data,
        output cam1_fv, cam1_lv, cam1_data,
        output cam_en, tx_ready,
        input  out_fv, out_lv, out_data, out_vc, busy, timeout_err
    );

endinterface

// File: rtl/dual_cam_frame_arbiter_cam_edge_detect.sv
// Registers a camera frame-valid and flags its rising edge; 1-cycle history, fv_rise is combinational.
// No backpressure: runs every cycle regardless of arbiter state.
module cam_edge_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic fv,
    output logic fv_rise
);

    logic fv_prev_q;
    logic fv_prev_d;

    always_comb begin
        fv_prev_d = fv;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            fv_prev_q <= 1'b0;
        end else begin
            fv_prev_q <= fv_prev_d;
        end
    end

    assign fv_rise = fv & ~fv_prev_q;

endmodule

// File: rtl/dual_cam_frame_arbiter.sv
// Grants whole frames from one of two cameras to a CSI-2 TX; out_* lag the granted camera by 1 cycle.
// Grants only on a fresh fv edge while tx_ready is high; optional drop counters under ARB_DROP_STATS_EN.
module dual_cam_frame_arbiter
    import dual_cam_frame_arbiter_pkg::*;
#(
    parameter int unsigned     GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int unsigned     TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [VC_W-1:0] VC0            = 2'd0,
    parameter logic [VC_W-1:0] VC1            = 2'd1
) (
    input  logic                    clock_in,
    input  logic                    reset,
    dual_cam_frame_arbiter_if.slave bus
`ifdef ARB_DROP_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]   drop_cnt0,
    output logic [DROP_CNT_W-1:0]   drop_cnt1
`endif
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic             rr_q, rr_d;
    logic [VC_W-1:0]  vc_q, vc_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    cam_beat_t        out_q, out_d;
    logic             terr_q, terr_d;
    logic             busy_q, busy_d;

    logic      rise0, rise1;
    logic      elig0, elig1;
    cam_beat_t beat0, beat1, sel_beat;

    cam_edge_detect u_edge0 (
        .clock_in (clock_in),
        .reset    (reset),
        .fv       (bus.cam0_fv),
        .fv_rise  (rise0)
    );

    cam_edge_detect u_edge1 (
        .clock_in (clock_in),
        .reset    (reset),
        .fv       (bus.cam1_fv),
        .fv_rise  (rise1)
    );

    assign beat0 = '{fv: bus.cam0_fv, lv: bus.cam0_lv, data: bus.cam0_data};
    assign beat1 = '{fv: bus.cam1_fv, lv: bus.cam1_lv, data: bus.cam1_data};

    // Enable mask and tx_ready only matter at the moment of grant.
    assign elig0 = rise0 & bus.cam_en[0] & bus.tx_ready;
    assign elig1 = rise1 & bus.cam_en[1] & bus.tx_ready;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        vc_d      = vc_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        out_d     = '0;
        terr_d    = 1'b0;
        sel_beat  = sel_q ? beat1 : beat0;

        case (state_q)
            ST_IDLE: begin
                if (elig0 || elig1) begin
                    sel_d    = (elig0 && elig1) ? rr_q : elig1;
                    vc_d     = sel_d ? VC1 : VC0;
                    out_d    = sel_d ? beat1 : beat0;
                    to_cnt_d = '0;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                // A normal frame end wins over a coincident timeout.
                if (!sel_beat.fv) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    rr_d      = ~sel_q;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    rr_d      = ~sel_q;
                    terr_d    = 1'b1;
                end else begin
                    out_d = sel_beat;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            rr_q      <= 1'b0;
            vc_q      <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            out_q     <= '0;
            terr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            vc_q      <= vc_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            out_q     <= out_d;
            terr_q    <= terr_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.out_fv      = out_q.fv;
    assign bus.out_lv      = out_q.lv;
    assign bus.out_data    = out_q.data;
    assign bus.out_vc      = vc_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;

`ifdef ARB_DROP_STATS_EN
    logic [DROP_CNT_W-1:0] drop0_q, drop0_d;
    logic [DROP_CNT_W-1:0] drop1_q, drop1_d;
    logic                  take0, take1;

    always_comb begin
        take0   = (state_q == ST_IDLE) && (state_d == ST_STREAM) && !sel_d;
        take1   = (state_q == ST_IDLE) && (state_d == ST_STREAM) &&  sel_d;
        drop0_d = drop0_q;
        drop1_d = drop1_q;
        if (rise0 && !take0 && (drop0_q != '1)) begin
            drop0_d = drop0_q + 1'b1;
        end
        if (rise1 && !take1 && (drop1_q != '1)) begin
            drop1_d = drop1_q + 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            drop0_q <= '0;
            drop1_q <= '0;
        end else begin
            drop0_q <= drop0_d;
            drop1_q <= drop1_d;
        end
    end

    assign drop_cnt0 = drop0_q;
    assign drop_cnt1 = drop1_q;
`endif

endmodule

// File: tb/tb_dual_cam_frame_arbiter.sv
// Directed bench for dual_cam_frame_arbiter: default instance plus a TIMEOUT_CYCLES=100 instance on shared inputs.
module tb_dual_cam_frame_arbiter;
    import dual_cam_frame_arbiter_pkg::*;

    localparam int GAP = 64;

    logic       clk;
    logic       rst;
    logic       c0_fv, c0_lv, c1_fv, c1_lv;
    logic [7:0] c0_dat, c1_dat;
    logic [1:0] cam_en;
    logic       tx_ready;

    int vectors;
    int miscompares;
    int pulses;

    dual_cam_frame_arbiter_if bus ();
    dual_cam_frame_arbiter_if bus_t ();

    assign bus.cam0_fv     = c0_fv;
    assign bus.cam0_lv     = c0_lv;
    assign bus.cam0_data   = c0_dat;
    assign bus.cam1_fv     = c1_fv;
    assign bus.cam1_lv     = c1_lv;
    assign bus.cam1_data   = c1_dat;
    assign bus.cam_en      = cam_en;
    assign bus.tx_ready    = tx_ready;
    assign bus_t.cam0_fv   = c0_fv;
    assign bus_t.cam0_lv   = c0_lv;
    assign bus_t.cam0_data = c0_dat;
    assign bus_t.cam1_fv   = c1_fv;
    assign bus_t.cam1_lv   = c1_lv;
    assign bus_t.cam1_data = c1_dat;
    assign bus_t.cam_en    = cam_en;
    assign bus_t.tx_ready  = tx_ready;

`ifdef ARB_DROP_STATS_EN
    logic [15:0] drop0, drop1, drop0_t, drop1_t;
    dual_cam_frame_arbiter u_dut (
        .clock_in (clk), .reset (rst), .bus (bus),
        .drop_cnt0 (drop0), .drop_cnt1 (drop1)
    );
    dual_cam_frame_arbiter #(.TIMEOUT_CYCLES(100)) u_dut_t (
        .clock_in (clk), .reset (rst), .bus (bus_t),
        .drop_cnt0 (drop0_t), .drop_cnt1 (drop1_t)
    );
`else
    dual_cam_frame_arbiter u_dut (
        .clock_in (clk), .reset (rst), .bus (bus)
    );
    dual_cam_frame_arbiter #(.TIMEOUT_CYCLES(100)) u_dut_t (
        .clock_in (clk), .reset (rst), .bus (bus_t)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cams_idle();
        c0_fv = 1'b0; c0_lv = 1'b0; c0_dat = 8'h00;
        c1_fv = 1'b0; c1_lv = 1'b0; c1_dat = 8'h00;
    endtask

    task automatic do_reset();
        cams_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Caller has just dropped the granted fv; GAP must last exactly GAP cycles.
    task automatic gap_wait(input string tag);
        tick();
        chk({tag, "_gap_first"}, {bus.busy, bus.out_fv, bus.out_lv}, 3'b100);
        repeat (GAP - 1) tick();
        chk({tag, "_gap_last"}, bus.busy, 1'b1);
        tick();
        chk({tag, "_gap_end"}, bus.busy, 1'b0);
    endtask

    initial begin
        logic [9:0] exp;
        vectors     = 0;
        miscompares = 0;
        cam_en      = 2'b11;
        tx_ready    = 1'b1;
        cams_idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out",   {bus.out_fv, bus.out_lv, bus.out_data}, 10'h000);
        chk("rst_vc",    bus.out_vc, 2'd0);
        chk("rst_busy",  bus.busy, 1'b0);
        chk("rst_terr",  bus.timeout_err, 1'b0);
        rst = 1'b0;

        // A: cam0 alone, 4 lines x 960 bytes
        c0_fv = 1'b1;
        tick();
        chk("A_grant", {bus.out_fv, bus.out_lv, bus.out_data}, 10'h200);
        chk("A_vc", bus.out_vc, 2'd0);
        chk("A_busy", bus.busy, 1'b1);
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < 964; b++) begin
                exp = (b < 960) ? {2'b11, 8'(b * 3 + l * 17)} : 10'h200;
                {c0_fv, c0_lv, c0_dat} = exp;
                tick();
                chk("A_stream", {bus.out_fv, bus.out_lv, bus.out_data}, exp);
            end
        end
        cams_idle();
        gap_wait("A");
        chk("A_vc_hold", bus.out_vc, 2'd0);

        // B: simultaneous rises, round-robin
        do_reset();
        c0_fv = 1'b1; c1_fv = 1'b1;
        tick();
        chk("B1_grant", {bus.out_fv, bus.out_vc}, 3'b100);
        c0_lv = 1'b1; c0_dat = 8'hA5; c1_lv = 1'b1; c1_dat = 8'h5A;
        tick();
        chk("B1_data", {bus.out_lv, bus.out_data}, 9'h1A5);
`ifdef ARB_DROP_STATS_EN
        chk("B1_drop1", drop1, 16'd1);
        chk("B1_drop0", drop0, 16'd0);
`endif
        cams_idle();
        gap_wait("B1");
        c0_fv = 1'b1; c0_lv = 1'b1; c0_dat = 8'h11;
        c1_fv = 1'b1; c1_lv = 1'b1; c1_dat = 8'h22;
        tick();
        chk("B2_vc", bus.out_vc, 2'd1);
        chk("B2_data", {bus.out_fv, bus.out_lv, bus.out_data}, 10'h322);
`ifdef ARB_DROP_STATS_EN
        chk("B2_drop0", drop0, 16'd1);
`endif
        cams_idle();
        gap_wait("B2");
        chk("B2_vc_hold", bus.out_vc, 2'd1);

        // C: cam1 rises mid cam0 frame and stays high past GAP
        do_reset();
        c0_fv = 1'b1;
        tick();
        chk("C_grant0", {bus.out_fv, bus.out_vc}, 3'b100);
        c0_lv = 1'b1; c0_dat = 8'h33;
        c1_fv = 1'b1; c1_lv = 1'b1; c1_dat = 8'h44;
        tick();
        chk("C_ignore1", {bus.out_lv, bus.out_data, bus.out_vc}, 11'b1_00110011_00);
        c0_fv = 1'b0; c0_lv = 1'b0; c0_dat = 8'h00;
        gap_wait("C");
        repeat (3) tick();
        chk("C_no_midgrant", {bus.out_fv, bus.busy}, 2'b00);
`ifdef ARB_DROP_STATS_EN
        chk("C_drop1", drop1, 16'd1);
`endif
        c1_fv = 1'b0; c1_lv = 1'b0;
        tick();
        c1_fv = 1'b1; c1_lv = 1'b1; c1_dat = 8'h55;
        tick();
        chk("C_grant1", {bus.out_fv, bus.out_data, bus.out_vc}, 11'b1_01010101_01);
        cams_idle();
        gap_wait("C1");

        // E: tx_ready low at rise, then enable-mask behaviour
        tx_ready = 1'b0;
        c0_fv = 1'b1;
        tick();
        chk("E_nogrant", {bus.out_fv, bus.busy}, 2'b00);
`ifdef ARB_DROP_STATS_EN
        chk("E_drop0", drop0, 16'd1);
`endif
        tx_ready = 1'b1;
        tick();
        chk("E_no_late_grant", bus.out_fv, 1'b0);
        c0_fv = 1'b0;
        tick();
        cam_en = 2'b10;
        c0_fv = 1'b1; c0_lv = 1'b1; c0_dat = 8'hC3;
        c1_fv = 1'b1; c1_lv = 1'b1; c1_dat = 8'h3C;
        tick();
        chk("EN_mask", {bus.out_data, bus.out_vc}, 10'b00111100_01);
`ifdef ARB_DROP_STATS_EN
        chk("EN_drop0", drop0, 16'd2);
`endif
        cam_en = 2'b00;
        tick();
        chk("EN_noabort", bus.out_fv, 1'b1);
        cams_idle();
        gap_wait("EN");
        cam_en = 2'b11;

        // D: timeout at 100 cycles on the short-timeout instance
        do_reset();
        c0_fv = 1'b1;
        tick();
        chk("D_start", bus_t.out_fv, 1'b1);
        pulses = 0;
        for (int i = 1; i < 100; i++) begin
            tick();
            if (bus_t.timeout_err) pulses++;
        end
        chk("D_hold99", bus_t.out_fv, 1'b1);
        tick();
        if (bus_t.timeout_err) pulses++;
        chk("D_abort", {bus_t.out_fv, bus_t.out_lv, bus_t.timeout_err, bus_t.busy}, 4'b0011);
        chk("D_default_runs", {bus.out_fv, bus.timeout_err}, 2'b10);
        repeat (10) begin
            tick();
            if (bus_t.timeout_err) pulses++;
        end
        chk("D_one_pulse", pulses, 1);
        chk("D_in_gap", {bus_t.busy, bus_t.out_fv}, 2'b10);

        // F: reset mid-frame on the default instance
        c0_lv = 1'b1; c0_dat = 8'h77;
        tick();
        chk("F_mid", {bus.out_fv, bus.out_lv, bus.out_data}, 10'h377);
        rst = 1'b1;
        tick();
        chk("F_out", {bus.out_fv, bus.out_lv, bus.out_data}, 10'h000);
        chk("F_state", {bus.busy, bus.out_vc, bus.timeout_err}, 4'b0000);
        chk("F_out_t", {bus_t.out_fv, bus_t.busy}, 2'b00);
        rst = 1'b0;
        cams_idle();
        tick();
        chk("F_idle", {bus.out_fv, bus.busy}, 2'b00);
        c0_fv = 1'b1; c0_lv = 1'b1; c0_dat = 8'h9E;
        c1_fv = 1'b1; c1_lv = 1'b1; c1_dat = 8'hE9;
        tick();
        chk("F_rr0", {bus.out_data, bus.out_vc}, 10'b10011110_00);
        cams_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
